// File: rtl/sseg_pkg.sv
// Types and constants shared by the seven-segment pattern generator and scan driver.
// Segment and anode buses are active-low: a 1 bit is dark.
package sseg_pkg;

  typedef logic [7:0] sseg_t;

  localparam int N_DIGITS = 4;
  localparam int DIGIT_W  = $clog2(N_DIGITS);

  localparam sseg_t                 SSEG_OFF = 8'hFF;
  localparam logic [N_DIGITS-1:0]   AN_OFF   = 4'hF;

  // Active-low one-hot anode select for a digit index.
  function automatic logic [N_DIGITS-1:0] an_select(input logic [DIGIT_W-1:0] digit);
    logic [N_DIGITS-1:0] onehot;
    onehot = '0;
    onehot[digit] = 1'b1;
    return ~onehot;
  endfunction

endpackage

// File: rtl/sseg_scan_timer.sv
// Slot timing for the digit scan: per-slot cycle counter and digit index, plus
// combinational decodes of the current state (frame start/end, leading blank window).
module sseg_scan_timer
  import sseg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [DIGIT_W-1:0] digit,
  output logic               frame_start,
  output logic               frame_end,
  output logic               in_blank
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0]      CNT_LAST   = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0]      CNT_BLANK  = CW'(BLANK_CYCLES);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(N_DIGITS - 1);

  logic [CW-1:0]      r_cnt;
  logic [DIGIT_W-1:0] r_digit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_digit <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt   <= '0;
      r_digit <= (r_digit == DIGIT_LAST) ? '0 : r_digit + DIGIT_W'(1);
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign digit       = r_digit;
  assign frame_start = (r_digit == '0) && (r_cnt == '0);
  assign frame_end   = (r_digit == DIGIT_LAST) && (r_cnt == CNT_LAST);
  // Every slot opens dark so the outgoing digit's anode has fully released.
  assign in_blank    = (r_cnt < CNT_BLANK);

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexes four active-low segment patterns onto a common-anode display with
// blanking, 16-level PWM and a per-frame input snapshot; outputs lag state by one clock.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  sseg_t               i_sseg_n [N_DIGITS-1:0],
  input  logic [3:0]          i_bright,
  input  logic                i_blank,
  output logic [N_DIGITS-1:0] o_an_n,
  output sseg_t               o_sseg_n,
  output logic                o_frame_tick
);

  logic [DIGIT_W-1:0] digit;
  logic               frame_start;
  logic               frame_end;
  logic               in_blank;
  logic [3:0]         r_pwm;
  sseg_t              r_frame [N_DIGITS-1:0];
  logic               lit;

  sseg_scan_timer #(
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .digit       (digit),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .in_blank    (in_blank)
  );

  // Whole-frame snapshot keeps a pattern update from tearing across digits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int d = 0; d < N_DIGITS; d++) r_frame[d] <= SSEG_OFF;
    end else if (frame_start) begin
      for (int d = 0; d < N_DIGITS; d++) r_frame[d] <= i_sseg_n[d];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_pwm <= '0;
    else       r_pwm <= r_pwm + 4'd1;
  end

  assign lit = !in_blank && (r_pwm <= i_bright) && !i_blank;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_an_n       <= AN_OFF;
      o_sseg_n     <= SSEG_OFF;
      o_frame_tick <= 1'b0;
    end else begin
      o_frame_tick <= frame_end;
      if (lit) begin
        o_an_n   <= an_select(digit);
        o_sseg_n <= r_frame[digit];
      end else begin
        o_an_n   <= AN_OFF;
        o_sseg_n <= SSEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Scoreboard bench for sseg_scan_driver: a time-indexed reference model queues the
// expected outputs at each rising edge; a monitor checks them on the falling edge.
module tb_sseg_scan_driver;
  import sseg_pkg::*;

  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int FRAME = N_DIGITS * DC;

  logic                i_clk = 1'b0;
  logic                i_rst;
  sseg_t               i_sseg_n [N_DIGITS-1:0];
  logic [3:0]          i_bright;
  logic                i_blank;
  logic [N_DIGITS-1:0] o_an_n;
  sseg_t               o_sseg_n;
  logic                o_frame_tick;

  sseg_scan_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_sseg_n     (i_sseg_n),
    .i_bright     (i_bright),
    .i_blank      (i_blank),
    .o_an_n       (o_an_n),
    .o_sseg_n     (o_sseg_n),
    .o_frame_tick (o_frame_tick)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [3:0] an;
    sseg_t      seg;
    logic       tick;
  } exp_t;

  exp_t  q[$];
  int    errors = 0;
  int    checks = 0;

  // Reference model: k counts clock edges since reset release; slot, digit and PWM
  // phase follow from k by division, the displayed pattern from the last frame start.
  int    k = 0;
  sseg_t m_frame [N_DIGITS];

  always @(posedge i_clk) begin
    exp_t e;
    int   slot;
    int   dig;
    int   pwm;
    e = '{an: 4'hF, seg: 8'hFF, tick: 1'b0};
    if (i_rst) begin
      k = 0;
      for (int d = 0; d < N_DIGITS; d++) m_frame[d] = 8'hFF;
    end else begin
      slot   = k % DC;
      dig    = (k / DC) % N_DIGITS;
      pwm    = k % 16;
      e.tick = ((k % FRAME) == FRAME - 1);
      if (slot >= BC && pwm <= int'(i_bright) && !i_blank) begin
        e.an  = 4'hF ^ (4'h1 << dig);
        e.seg = m_frame[dig];
      end
      if ((k % FRAME) == 0)
        for (int d = 0; d < N_DIGITS; d++) m_frame[d] = i_sseg_n[d];
      k++;
    end
    q.push_back(e);
  end

  always @(negedge i_clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({o_an_n, o_sseg_n, o_frame_tick} !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: an=%b seg=%h tick=%b, want an=%b seg=%h tick=%b",
                 $time, o_an_n, o_sseg_n, o_frame_tick, e.an, e.seg, e.tick);
      end
      checks++;
      if ($countones(~o_an_n) > 1) begin
        errors++;
        $display("FAIL anode_overlap t=%0t: an=%b, want at most one low", $time, o_an_n);
      end
    end
  end

  task automatic run(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clk);
  endtask

  initial begin
    int waited;
    i_rst    = 1'b1;
    i_bright = 4'd15;
    i_blank  = 1'b0;
    i_sseg_n[0] = 8'hF9;
    i_sseg_n[1] = 8'hC0;
    i_sseg_n[2] = 8'hA3;
    i_sseg_n[3] = 8'h9C;
    run(3);
    i_rst = 1'b0;

    // Two full frames with a fixed pattern, then a mid-frame change to digit 2.
    run(2 * FRAME + 12);
    i_sseg_n[2] = 8'h00;
    run(2 * FRAME);

    // Reduced brightness, then full.
    i_bright = 4'd3;
    run(4 * FRAME);
    i_bright = 4'd15;
    run(FRAME + 12);

    // Forced blank mid-frame.
    i_blank = 1'b1;
    run(10);
    i_blank = 1'b0;
    run(FRAME + 6);

    // Reset while digit 2 is lit, with a new pattern present at release.
    waited = 0;
    while (o_an_n !== 4'b1011 && waited < 200) begin
      run(1);
      waited++;
    end
    checks++;
    if (o_an_n !== 4'b1011) begin
      errors++;
      $display("FAIL wait_digit2: an=%b after %0d clocks, want 1011", o_an_n, waited);
    end
    i_rst = 1'b1;
    run(1);
    i_sseg_n[0] = 8'h12;
    i_rst = 1'b0;
    run(FRAME + 8);

    // Randomized operation with occasional resets, blanking and pattern updates.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) i_bright = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) i_blank = ~i_blank;
      if ($urandom_range(0, 9) == 0) i_sseg_n[$urandom_range(0, 3)] = 8'($urandom);
      i_rst = ($urandom_range(0, 399) == 0);
      run(1);
    end
    i_rst   = 1'b0;
    i_blank = 1'b0;
    run(FRAME);

    @(posedge i_clk);
    @(negedge i_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
